// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch (IF) and load/store (MEM).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise MEM has fixed priority over IF.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              stall_req,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       grant_mem;   // 1 = MEM owns the current access, 0 = IF
    logic       pick_mem;
    logic       any_req;

    assign any_req = if_req | mem_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;        // 1 = MEM was served last, 0 = IF

    // On contention, serve whichever requester was not served last.
    assign pick_mem = mem_req & (~if_req | ~last_grant);

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b0;
        else if (state == IDLE && any_req)
            last_grant <= pick_mem;
    end
`else
    assign pick_mem = mem_req;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)    state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_mem <= 1'b0;
            cnt       <= 4'd0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_sel   <= 4'd0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_mem <= pick_mem;
                        ram_ce    <= 1'b1;
                        cnt       <= CNT_INIT;
                        if (pick_mem) begin
                            ram_we    <= mem_we;
                            ram_sel   <= mem_sel;
                            ram_addr  <= mem_addr;
                            ram_wdata <= mem_wdata;
                        end else begin
                            ram_we    <= 1'b0;
                            ram_sel   <= 4'hF;
                            ram_addr  <= if_addr;
                            ram_wdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Stores leave mem_rdata untouched.
                        if (grant_mem && !ram_we)
                            mem_rdata <= ram_rdata;
                        if (!grant_mem)
                            if_rdata <= ram_rdata;
                        ram_ce  <= 1'b0;
                        ram_we  <= 1'b0;
                        mem_ack <= grant_mem;
                        if_ack  <= ~grant_mem;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance "a" runs with WAIT_CYCLES=1, instance "b" with WAIT_CYCLES=3.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_rst, a_if_req, a_if_ack, a_mem_req, a_mem_we, a_mem_ack, a_stall;
    logic        a_ram_ce, a_ram_we;
    logic [3:0]  a_mem_sel, a_ram_sel;
    logic [31:0] a_if_addr, a_if_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

    logic        b_rst, b_if_req, b_if_ack, b_mem_req, b_mem_we, b_mem_ack, b_stall;
    logic        b_ram_ce, b_ram_we;
    logic [3:0]  b_mem_sel, b_ram_sel;
    logic [31:0] b_if_addr, b_if_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(a_rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_sel(a_mem_sel), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
        .stall_req(a_stall), .ram_ce(a_ram_ce), .ram_we(a_ram_we), .ram_sel(a_ram_sel),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(b_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_sel(b_mem_sel), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
        .stall_req(b_stall), .ram_ce(b_ram_ce), .ram_we(b_ram_we), .ram_sel(b_ram_sel),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    bit first_mem;

    initial begin
        a_rst = 1; a_if_req = 0; a_if_addr = 0; a_mem_req = 0; a_mem_we = 0;
        a_mem_sel = 0; a_mem_addr = 0; a_mem_wdata = 0; a_ram_rdata = 0;
        b_rst = 1; b_if_req = 0; b_if_addr = 0; b_mem_req = 0; b_mem_we = 0;
        b_mem_sel = 0; b_mem_addr = 0; b_mem_wdata = 0; b_ram_rdata = 0;
        step(); step();
        a_rst = 0; b_rst = 0;

        // reset state
        chk("rst_a_ce", a_ram_ce, 0);
        chk("rst_a_ack", {a_if_ack, a_mem_ack}, 0);
        chk("rst_a_rdata", {a_if_rdata, a_mem_rdata}, 0);
        chk("rst_a_stall", a_stall, 0);
        chk("rst_b_ram", {b_ram_ce, b_ram_we, b_ram_sel, b_ram_addr}, 0);
        step();

        // single fetch, WAIT_CYCLES=1
        a_if_req = 1; a_if_addr = 32'h10; a_ram_rdata = 32'h34010020;
        #1;
        chk("f_T_stall", a_stall, 1);
        chk("f_T_ce", a_ram_ce, 0);
        step();
        chk("f_T1_ce", a_ram_ce, 1);
        chk("f_T1_we_sel", {a_ram_we, a_ram_sel}, 5'h0F);
        chk("f_T1_addr", a_ram_addr, 32'h10);
        chk("f_T1_ack", a_if_ack, 0);
        chk("f_T1_stall", a_stall, 1);
        step();
        chk("f_T2_ack", a_if_ack, 1);
        chk("f_T2_ce", a_ram_ce, 0);
        chk("f_T2_rdata", a_if_rdata, 32'h34010020);
        chk("f_T2_stall", a_stall, 0);
        step();
        a_if_req = 0;
        chk("f_T3_ack", a_if_ack, 0);
        step();

        // store, WAIT_CYCLES=3
        b_mem_req = 1; b_mem_we = 1; b_mem_sel = 4'b0011; b_mem_addr = 32'h100;
        b_mem_wdata = 32'hDEADBEEF; b_ram_rdata = 32'h55555555;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("st_ce_we", {b_ram_ce, b_ram_we}, 2'b11);
            chk("st_sel_addr", {b_ram_sel, b_ram_addr}, {4'b0011, 32'h100});
            chk("st_wdata", b_ram_wdata, 32'hDEADBEEF);
            chk("st_noack", b_mem_ack, 0);
        end
        step();
        chk("st_T4_ack", b_mem_ack, 1);
        chk("st_T4_ce_we", {b_ram_ce, b_ram_we}, 0);
        chk("st_T4_rdata", b_mem_rdata, 0);
        step();
        b_mem_req = 0; b_mem_we = 0;

        // back-to-back fetches, WAIT_CYCLES=1
        a_if_req = 1; a_if_addr = 32'h20; a_ram_rdata = 32'h00000001;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 9) a_if_req = 0;
            chk("b2b_ack", a_if_ack, (c == 2 || c == 5 || c == 8) ? 1 : 0);
        end
        chk("b2b_rdata", a_if_rdata, 32'h00000001);
        step();

        // single load so MEM is the last-served requester
        a_mem_req = 1; a_mem_we = 0; a_mem_sel = 4'hF; a_mem_addr = 32'h200;
        a_ram_rdata = 32'hCAFEF00D;
        step(); step();
        chk("ld_ack", a_mem_ack, 1);
        chk("ld_rdata", a_mem_rdata, 32'hCAFEF00D);
        step();
        a_mem_req = 0;
        step();

        // simultaneous requests
        first_mem = !RR;
        a_if_req = 1; a_mem_req = 1; a_if_addr = 32'h30; a_mem_addr = 32'h300;
        a_ram_rdata = 32'h11112222;
        step();
        chk("dual_T1_addr", a_ram_addr, first_mem ? 32'h300 : 32'h30);
        step();
        chk("dual_T2_acks", {a_mem_ack, a_if_ack}, first_mem ? 2'b10 : 2'b01);
        step();
        if (first_mem) a_mem_req = 0; else a_if_req = 0;
        chk("dual_T3_acks", {a_mem_ack, a_if_ack}, 2'b00);
        step(); step();
        chk("dual_T5_acks", {a_mem_ack, a_if_ack}, first_mem ? 2'b01 : 2'b10);
        chk("dual_T5_stall", a_stall, 0);
        step();
        a_if_req = 0; a_mem_req = 0;
        step();

        // continuous dual requests
        a_if_req = 1; a_mem_req = 1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 9) begin a_if_req = 0; a_mem_req = 0; end
            if (c == 2 || c == 8)
                chk("cont_ack_a", {a_mem_ack, a_if_ack}, RR ? 2'b01 : 2'b10);
            else if (c == 5)
                chk("cont_ack_b", {a_mem_ack, a_if_ack}, 2'b10);
            else
                chk("cont_noack", {a_mem_ack, a_if_ack}, 2'b00);
        end
        step();

        // reset in the middle of a WAIT_CYCLES=3 fetch
        b_if_req = 1; b_if_addr = 32'h40; b_ram_rdata = 32'h77777777;
        step();
        chk("rm_T1_ce", b_ram_ce, 1);
        b_rst = 1; b_if_req = 0;
        step();
        chk("rm_T2_ram", {b_ram_ce, b_ram_we, b_ram_sel, b_ram_addr}, 0);
        chk("rm_T2_out", {b_if_ack, b_mem_ack, b_stall, b_if_rdata}, 0);
        b_rst = 0;
        for (int c = 3; c <= 6; c++) begin
            step();
            chk("rm_noack", {b_if_ack, b_mem_ack, b_ram_ce}, 0);
        end

        // fresh load after reset
        b_mem_req = 1; b_mem_we = 0; b_mem_sel = 4'hF; b_mem_addr = 32'h180;
        b_ram_rdata = 32'hA5A5A5A5;
        step();
        chk("rl_T1_ce_we", {b_ram_ce, b_ram_we}, 2'b10);
        step(); step(); step();
        chk("rl_T4_ack", b_mem_ack, 1);
        chk("rl_T4_rdata", b_mem_rdata, 32'hA5A5A5A5);
        chk("rl_T4_if_rdata", b_if_rdata, 0);
        step();
        b_mem_req = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
